// File: rtl/div_rem_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with a divReady handshake.
// state | meaning: IDLE wait for request; BUSY one quotient bit per cycle; FIX sign-correct into Result; DONE hold Result
module div_rem_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] OP_DIV  = 5'd20,
  parameter logic [4:0] OP_DIVU = 5'd21,
  parameter logic [4:0] OP_REM  = 5'd22,
  parameter logic [4:0] OP_REMU = 5'd23
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             divReady,
  output logic             div_op
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [4:0]       req_aluc;
  logic [WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             signed_op, req_match, accept, div_zero, ovf, special, is_rem;
  logic [WIDTH-1:0] abs_a, abs_b, fix_val;
  logic [WIDTH:0]   trial;

  assign div_op    = (aluc == OP_DIV) || (aluc == OP_DIVU) || (aluc == OP_REM) || (aluc == OP_REMU);
  assign signed_op = (aluc == OP_DIV) || (aluc == OP_REM);
  assign req_match = ({aluc, A, B} == {req_aluc, req_a, req_b});
  assign accept    = div_op && ((state == IDLE) || ((state == DONE) && !req_match));
  assign div_zero  = (B == '0);
  assign ovf       = signed_op && (A == MIN_INT) && (B == '1);
  assign special   = div_zero || ovf;
  assign abs_a     = (signed_op && A[WIDTH-1]) ? -A : A;
  assign abs_b     = (signed_op && B[WIDTH-1]) ? -B : B;
  assign is_rem    = (req_aluc == OP_REM) || (req_aluc == OP_REMU);

  // Trial is one bit wider: the shifted partial remainder can exceed WIDTH bits.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  always_comb begin
    fix_val = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? FIX : BUSY;
      BUSY: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        if (!req_match) begin
          if (accept) state_nxt = special ? FIX : BUSY;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Special cases preload their final values so FIX just passes them through.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      req_aluc <= '0;
      req_a    <= '0;
      req_b    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      Result   <= '0;
      divReady <= 1'b1;
    end else if (accept) begin
      req_aluc <= aluc;
      req_a    <= A;
      req_b    <= B;
      cnt      <= CW'(WIDTH-1);
      divReady <= 1'b0;
      dvs      <= abs_b;
      if (special) begin
        quo   <= div_zero ? '1 : MIN_INT;
        rem   <= div_zero ? A : '0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        quo   <= abs_a;
        rem   <= '0;
        neg_q <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
        neg_r <= signed_op && A[WIDTH-1];
      end
    end else if (state == BUSY) begin
      rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      Result   <= fix_val;
      divReady <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed bench for div_rem_unit: results, latency, hold/re-issue, reset and input-change behaviour.
module tb_div_rem_unit;
  localparam logic [4:0] OP_DIV  = 5'd20;
  localparam logic [4:0] OP_DIVU = 5'd21;
  localparam logic [4:0] OP_REM  = 5'd22;
  localparam logic [4:0] OP_REMU = 5'd23;

  logic        CLK;
  logic        RESET;
  logic [4:0]  aluc;
  logic [31:0] A, B, Result;
  logic        divReady, div_op;

  int vectors = 0;
  int miscompares = 0;

  div_rem_unit dut (
    .CLK(CLK), .RESET(RESET), .aluc(aluc), .A(A), .B(B),
    .Result(Result), .divReady(divReady), .div_op(div_op)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Applies a request and counts cycles divReady is low (bounded).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int low);
    aluc = op; A = a; B = b; low = 0;
    step();
    while (divReady === 1'b0 && low < 100) begin
      low++;
      step();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; aluc = 5'd0; A = '0; B = '0;
    step();
    step();
    RESET = 1'b1;
    vectors++; if (divReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", divReady); end
    vectors++; if (Result !== 32'd0) begin miscompares++; $display("FAIL reset_result got %h want 0", Result); end
    aluc = 5'd19; A = 32'd100; B = 32'd3;
    #1;
    vectors++; if (div_op !== 1'b0) begin miscompares++; $display("FAIL div_op_19 got %b want 0", div_op); end
    step();
    vectors++; if (divReady !== 1'b1) begin miscompares++; $display("FAIL idle_nondiv_ready got %b want 1", divReady); end
    aluc = 5'd24;
    #1;
    vectors++; if (div_op !== 1'b0) begin miscompares++; $display("FAIL div_op_24 got %b want 0", div_op); end
    aluc = OP_REMU;
    #1;
    vectors++; if (div_op !== 1'b1) begin miscompares++; $display("FAIL div_op_23 got %b want 1", div_op); end
    aluc = 5'd0;
  endtask

  task automatic test_basic();
    int low;
    issue(OP_DIV, 32'd100, 32'd3, low);
    vectors++; if (Result !== 32'd33) begin miscompares++; $display("FAIL div_100_3 got %h want %h", Result, 32'd33); end
    vectors++; if (low != 33) begin miscompares++; $display("FAIL div_latency got %0d want 33", low); end
    issue(OP_DIVU, 32'd100, 32'd3, low);
    vectors++; if (Result !== 32'd33 || low != 33) begin miscompares++; $display("FAIL divu_100_3 got %h/%0d want 21/33", Result, low); end
    issue(OP_REM, 32'd100, 32'd3, low);
    vectors++; if (Result !== 32'd1 || low != 33) begin miscompares++; $display("FAIL rem_100_3 got %h/%0d want 1/33", Result, low); end
    issue(OP_REMU, 32'd100, 32'd3, low);
    vectors++; if (Result !== 32'd1 || low != 33) begin miscompares++; $display("FAIL remu_100_3 got %h/%0d want 1/33", Result, low); end
  endtask

  task automatic test_signed();
    int low;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, low);
    vectors++; if (Result !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_m7_2 got %h want fffffffd", Result); end
    issue(OP_REM, 32'hFFFFFFF9, 32'd2, low);
    vectors++; if (Result !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL rem_m7_2 got %h want ffffffff", Result); end
    issue(OP_DIVU, 32'hFFFFFFF9, 32'd2, low);
    vectors++; if (Result !== 32'h7FFFFFFC) begin miscompares++; $display("FAIL divu_fff9_2 got %h want 7ffffffc", Result); end
    issue(OP_REMU, 32'hFFFFFFF9, 32'd2, low);
    vectors++; if (Result !== 32'd1) begin miscompares++; $display("FAIL remu_fff9_2 got %h want 1", Result); end
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, low);
    vectors++; if (Result !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_7_m2 got %h want fffffffd", Result); end
    issue(OP_REM, 32'hFFFFFFF9, 32'hFFFFFFFE, low);
    vectors++; if (Result !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL rem_m7_m2 got %h want ffffffff", Result); end
  endtask

  task automatic test_special();
    int low;
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, low);
    vectors++; if (Result !== 32'h80000000 || low != 1) begin miscompares++; $display("FAIL div_ovf got %h/%0d want 80000000/1", Result, low); end
    issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, low);
    vectors++; if (Result !== 32'd0 || low != 1) begin miscompares++; $display("FAIL rem_ovf got %h/%0d want 0/1", Result, low); end
    issue(OP_DIV, 32'd123, 32'd0, low);
    vectors++; if (Result !== 32'hFFFFFFFF || low != 1) begin miscompares++; $display("FAIL div_by0 got %h/%0d want ffffffff/1", Result, low); end
    issue(OP_REM, 32'd123, 32'd0, low);
    vectors++; if (Result !== 32'd123 || low != 1) begin miscompares++; $display("FAIL rem_by0 got %h/%0d want 7b/1", Result, low); end
    issue(OP_DIVU, 32'd123, 32'd0, low);
    vectors++; if (Result !== 32'hFFFFFFFF || low != 1) begin miscompares++; $display("FAIL divu_by0 got %h/%0d want ffffffff/1", Result, low); end
    issue(OP_REMU, 32'd123, 32'd0, low);
    vectors++; if (Result !== 32'd123 || low != 1) begin miscompares++; $display("FAIL remu_by0 got %h/%0d want 7b/1", Result, low); end
    issue(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, low);
    vectors++; if (Result !== 32'd0 || low != 33) begin miscompares++; $display("FAIL divu_big got %h/%0d want 0/33", Result, low); end
    issue(OP_REMU, 32'h80000000, 32'hFFFFFFFF, low);
    vectors++; if (Result !== 32'h80000000 || low != 33) begin miscompares++; $display("FAIL remu_big got %h/%0d want 80000000/33", Result, low); end
  endtask

  task automatic test_hold_reissue();
    int low;
    int drops;
    issue(OP_DIV, 32'd100, 32'd3, low);
    vectors++; if (Result !== 32'd33) begin miscompares++; $display("FAIL hold_setup got %h want 21", Result); end
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (divReady !== 1'b1 || Result !== 32'd33) drops++;
    end
    vectors++; if (drops != 0) begin miscompares++; $display("FAIL hold_stable got %0d drops want 0", drops); end
    issue(OP_DIV, 32'd100, 32'd7, low);
    vectors++; if (Result !== 32'd14 || low != 33) begin miscompares++; $display("FAIL reissue_b7 got %h/%0d want e/33", Result, low); end
  endtask

  task automatic test_reset_mid_op();
    int low;
    aluc = OP_DIV; A = 32'd100; B = 32'd3;
    step();
    for (int i = 0; i < 9; i++) step();
    vectors++; if (divReady !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", divReady); end
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    vectors++; if (divReady !== 1'b1 || Result !== 32'd0) begin miscompares++; $display("FAIL mid_reset got %b/%h want 1/0", divReady, Result); end
    issue(OP_DIV, 32'd100, 32'd3, low);
    vectors++; if (Result !== 32'd33 || low != 33) begin miscompares++; $display("FAIL after_reset got %h/%0d want 21/33", Result, low); end
  endtask

  task automatic test_input_change();
    int low;
    int idle_bad;
    aluc = OP_DIVU; A = 32'd1000; B = 32'd7; low = 0;
    step();
    while (divReady === 1'b0 && low < 100) begin
      low++;
      if (low == 3) begin aluc = 5'd0; A = 32'd9; B = 32'd9; end
      if (low == 5) begin aluc = OP_REMU; A = 32'd50; B = 32'd8; end
      step();
    end
    vectors++; if (Result !== 32'd142 || low != 33) begin miscompares++; $display("FAIL orig_kept got %h/%0d want 8e/33", Result, low); end
    issue(OP_REMU, 32'd50, 32'd8, low);
    vectors++; if (Result !== 32'd2 || low != 33) begin miscompares++; $display("FAIL new_from_done got %h/%0d want 2/33", Result, low); end
    aluc = 5'd0;
    idle_bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (divReady !== 1'b1 || Result !== 32'd2) idle_bad++;
    end
    vectors++; if (idle_bad != 0) begin miscompares++; $display("FAIL idle_hold got %0d bad want 0", idle_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_special();
    test_hold_reissue();
    test_reset_mid_op();
    test_input_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
